// File: rtl/alu_pkg.sv
// Shared types for seq_alu: opcode and FSM state encodings.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Divider logic is present only when SEQ_ALU_DIV_EN is defined.
// o_done_c / o_lo_c / o_hi_c are combinational: on the last step they carry
// the final result so the caller can register it on that same edge.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
`ifdef SEQ_ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_lo_c,
  output logic [WIDTH-1:0] o_hi_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
`ifdef SEQ_ALU_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
`endif

  // One step of each engine from the current partial state
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : (WIDTH+1)'(0));
    w_mul_hi  = w_mul_sum[WIDTH:1];
    w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    w_div_diff = w_div_sh - {1'b0, r_b};
    w_div_ge   = (w_div_sh >= {1'b0, r_b});
    w_div_hi   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    w_div_lo   = {r_lo[WIDTH-2:0], w_div_ge};
    o_lo_c     = r_div ? w_div_lo : w_mul_lo;
    o_hi_c     = r_div ? w_div_hi : w_mul_hi;
`else
    o_lo_c     = w_mul_lo;
    o_hi_c     = w_mul_hi;
`endif
  end

  assign o_busy   = r_busy;
  assign o_done_c = r_busy && (r_cnt == CNT_LAST);

  // Load on start, then iterate; counter saturates at the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_hi   <= '0;
`ifdef SEQ_ALU_DIV_EN
      r_div  <= i_div;
      r_b    <= i_div ? i_b : i_a;
      r_lo   <= i_div ? i_a : i_b;
`else
      r_b    <= i_a;
      r_lo   <= i_b;
`endif
    end else if (r_busy) begin
      r_hi <= o_hi_c;
      r_lo <= o_lo_c;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle 8-op ALU with valid/ready on both sides and status flags.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise opcode 6 returns 0.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OP_W-1:0]  selector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             dbz
);

  state_e           r_state, w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_x, r_y;
  logic [WIDTH-1:0] r_lo, r_hi, w_lo_nxt, w_hi_nxt;
  logic             r_carry, r_zero, r_dbz, r_out_valid, r_in_ready;
  logic             w_carry_nxt, w_zero_nxt, w_dbz_nxt, w_out_valid_nxt, w_in_ready_nxt;
  logic             w_finish, w_core_start, w_core_busy, w_core_done;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_core_lo, w_core_hi;
  op_e              w_in_op;

  assign w_in_op   = op_e'(selector);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result_lo = r_lo;
  assign result_hi = r_hi;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign dbz       = r_dbz;

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_core_start),
`ifdef SEQ_ALU_DIV_EN
    .i_div    (w_in_op == OP_DIV),
`endif
    .i_a      (x),
    .i_b      (y),
    .o_busy   (w_core_busy),
    .o_done_c (w_core_done),
    .o_lo_c   (w_core_lo),
    .o_hi_c   (w_core_hi)
  );

  // Next state, next registered outputs, and core start
  always_comb begin
    w_state_nxt     = r_state;
    w_lo_nxt        = r_lo;
    w_hi_nxt        = r_hi;
    w_carry_nxt     = r_carry;
    w_zero_nxt      = r_zero;
    w_dbz_nxt       = r_dbz;
    w_out_valid_nxt = r_out_valid;
    w_finish        = 1'b0;
    w_core_start    = 1'b0;
    w_sum           = '0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_EXEC;
`ifdef SEQ_ALU_DIV_EN
          w_core_start = !w_core_busy &&
                         ((w_in_op == OP_MUL) || ((w_in_op == OP_DIV) && (y != '0)));
`else
          w_core_start = !w_core_busy && (w_in_op == OP_MUL);
`endif
        end
      end
      S_EXEC: begin
        w_hi_nxt    = '0;
        w_carry_nxt = 1'b0;
        w_dbz_nxt   = 1'b0;
        case (r_op)
          OP_ADD: begin
            w_sum       = {1'b0, r_x} + {1'b0, r_y};
            w_lo_nxt    = w_sum[WIDTH-1:0];
            w_carry_nxt = w_sum[WIDTH];
            w_finish    = 1'b1;
          end
          OP_SUB: begin
            w_sum       = {1'b0, r_x} - {1'b0, r_y};
            w_lo_nxt    = w_sum[WIDTH-1:0];
            w_carry_nxt = w_sum[WIDTH];
            w_finish    = 1'b1;
          end
          OP_AND: begin w_lo_nxt = r_x & r_y; w_finish = 1'b1; end
          OP_OR:  begin w_lo_nxt = r_x | r_y; w_finish = 1'b1; end
          OP_XOR: begin w_lo_nxt = r_x ^ r_y; w_finish = 1'b1; end
          OP_MUL: begin
            w_lo_nxt = w_core_lo;
            w_hi_nxt = w_core_hi;
            w_finish = w_core_done;
          end
          OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
            if (r_y == '0) begin
              w_lo_nxt  = '1;
              w_hi_nxt  = r_x;
              w_dbz_nxt = 1'b1;
              w_finish  = 1'b1;
            end else begin
              w_lo_nxt = w_core_lo;
              w_hi_nxt = w_core_hi;
              w_finish = w_core_done;
            end
`else
            w_lo_nxt = '0;
            w_finish = 1'b1;
`endif
          end
          OP_CMP: begin
            w_lo_nxt    = '0;
            w_lo_nxt[2] = (r_x > r_y);
            w_lo_nxt[1] = (r_x == r_y);
            w_lo_nxt[0] = (r_x < r_y);
            w_finish    = 1'b1;
          end
          default: w_finish = 1'b1;
        endcase
        if (w_finish) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_zero_nxt      = ({w_hi_nxt, w_lo_nxt} == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_carry     <= w_carry_nxt;
      r_zero      <= w_zero_nxt;
      r_dbz       <= w_dbz_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // Operand capture on acceptance only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_op <= OP_ADD;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_x  <= x;
      r_y  <= y;
      r_op <= w_in_op;
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU that generalises the lab's 8-bit combinational 4-op ALU. It supports a configurable operand width, eight operations, iterative multiply and divide, a valid/ready handshake on both the operand side and the result side, and status flags. It sits between a register-file/controller stage and writeback, and accepts one operation at a time.

## Interface
- WIDTH, 8: operand width in bits (4..32).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; one clock, synchronous reset, active low.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept; high only in IDLE.
- x  in  WIDTH  operand A (unsigned).
- y  in  WIDTH  operand B (unsigned).
- selector  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 CMP.
- out_valid  out  1  result is available; held until accepted.
- out_ready  in  1  consumer takes the result.
- result_lo  out  WIDTH  primary result.
- result_hi  out  WIDTH  MUL upper half or DIV remainder; 0 for all other ops.
- carry  out  1  ADD carry-out or SUB borrow; 0 for all other ops.
- zero  out  1  {result_hi,result_lo} == 0.
- dbz  out  1  DIV with y == 0.

## Operation
- FSM states: IDLE, EXEC, DONE. Reset puts the FSM in IDLE and drives every output to 0, except in_ready, which is 1.
- IDLE: when in_valid is high, capture x, y and selector, then go to EXEC. in_ready is 0 in every state except IDLE.
- EXEC for ops 0-4 and 7: compute in one cycle, then go to DONE.
  - ADD/SUB: result is {carry, result_lo} = x ± y, modulo 2^WIDTH, with carry as the (WIDTH+1)th bit.
  - CMP: result_lo = {WIDTH-3 zeros, x>y, x==y, x<y}.
- EXEC for MUL: shift-add, one bit per cycle, WIDTH iterations. Result {result_hi, result_lo} = x*y, 2*WIDTH bits, exact.
- EXEC for DIV: restoring division, WIDTH iterations. result_lo = quotient, result_hi = remainder.
  - y == 0: skip iteration. result_lo = all ones, result_hi = x, dbz = 1, go to DONE after one cycle.
- DONE: out_valid = 1 and outputs are stable. When out_ready is high, clear out_valid and go to IDLE. Otherwise hold indefinitely.
- New in_valid pulses during EXEC or DONE are ignored; they are not queued.
- rst_n low in any state aborts the operation on that edge. No partial result is ever emitted.

## Timing
- Latency, counted from the acceptance edge (in_valid & in_ready) to out_valid high:
  - ops 0-4 and 7: 2 edges.
  - MUL/DIV: WIDTH+1 edges.
  - DIV by zero: 2 edges.
- Outputs are registered. out_valid and in_ready are never high in the same cycle.
- Back-to-back operation: after out_valid & out_ready, in_ready rises on the next cycle. Throughput is one op per latency+1 cycles.
- The iteration counter is $clog2(WIDTH)+1 bits. It saturates and never wraps mid-operation.

## Configuration
- SEQ_ALU_DIV_EN defined: DIV is implemented as above.
- SEQ_ALU_DIV_EN undefined: no divider logic is compiled. Opcode 6 completes in 2 edges with result_lo = 0, result_hi = 0, dbz = 0, zero = 1.

## Structure
- Shared package alu_pkg holds the opcode enum (OP_ADD..OP_CMP), the state enum (S_IDLE, S_EXEC, S_DONE) and the 3-bit opcode width constant.
- One sub-module, seq_muldiv_core, holds the iterative shift-add/restoring engine and its counter. It is parametrised by WIDTH and has start/busy/done handshake lines. The top holds the FSM, handshakes, single-cycle ops and flags.

## Test plan (WIDTH=8 unless stated)
- ADD 200+100 -> result_lo=44, carry=1, out_valid after 2 edges. SUB 5-7 -> result_lo=254, carry=1.
- MUL 255*255 -> {hi,lo}=16'hFE01 after 9 edges. MUL 0*x -> zero=1.
- DIV 200/7 -> lo=28, hi=4. DIV 13/0 -> lo=255, hi=13, dbz=1, 2 edges. Without SEQ_ALU_DIV_EN: 13/7 -> lo=0, zero=1.
- Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0. Pulse in_valid with different operands -> ignored. Result unchanged on release.
- Assert rst_n=0 mid-MUL (iteration 4) -> next cycle in_ready=1 and out_valid=0. A following ADD 1+1 -> 2.
- WIDTH=16: sweep all 8 ops with random operands against a reference model. CMP 3 vs 3 -> lo=16'h0002.
